adc_boxcar_decimator: RTL

- Upstream stage of the LED level decoder in the frequency-counter example.
- Takes the raw 125 MS/s ADC AXI-Stream, averages 2^k consecutive samples of channel A (boxcar), and emits one averaged sample per window on an AXI-Stream master.
- The decoder downstream then sees a stable, low-noise level instead of per-sample jitter.
- k is selected at runtime from GPIO.

---
 rtl/adc_boxcar_decimator_pkg.sv | 12 +
 rtl/adc_boxcar_decimator_boxcar_accumulator.sv | 38 +++
 rtl/adc_boxcar_decimator.sv | 50 +++++
 3 files changed

// File: rtl/adc_boxcar_decimator_pkg.sv
// adc_boxcar_decimator_pkg: shared widths and output field layout for the ADC boxcar path
package adc_boxcar_decimator_pkg;
  localparam int ADC_WIDTH_DEF = 14;
  localparam int LOG2_N_MAX_DEF = 10;
  localparam int KW = 4;
  localparam int OUT_LSB = 0;
  localparam int OUT_MSB = 15;
  localparam int OUT_W = OUT_MSB - OUT_LSB + 1;
  function automatic int acc_width(input int adc_width, input int log2_n_max);
    return adc_width + log2_n_max;
  endfunction
endpackage

// File: rtl/adc_boxcar_decimator_boxcar_accumulator.sv
// boxcar_accumulator: sums 2^k samples and produces the floored mean at the window end
module boxcar_accumulator
  import adc_boxcar_decimator_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int LOG2_N_MAX = LOG2_N_MAX_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  input  logic                        clear,
  input  logic [KW-1:0]               k,
  input  logic signed [ADC_WIDTH-1:0] sample,
  output logic                        last,
  output logic signed [ADC_WIDTH-1:0] avg
);
  localparam int AW = acc_width(ADC_WIDTH, LOG2_N_MAX);
  logic signed [AW-1:0] acc, s, sum;
  logic [LOG2_N_MAX-1:0] cnt, cnt_end;
  assign s = {{LOG2_N_MAX{sample[ADC_WIDTH-1]}}, sample};
  assign sum = acc + s;
  assign cnt_end = ~({LOG2_N_MAX{1'b1}} << k);
  assign last = valid && !clear && cnt == cnt_end;
  assign avg = ADC_WIDTH'(sum >>> k);
  // accumulate valid samples; restart on clear or when the window closes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear || last) begin
      acc <= '0;
      cnt <= '0;
    end else if (valid) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/adc_boxcar_decimator.sv
// adc_boxcar_decimator: averages 2^k channel-A ADC samples and emits one AXIS beat per window
module adc_boxcar_decimator
  import adc_boxcar_decimator_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LOG2_N_MAX = LOG2_N_MAX_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  input  logic [KW-1:0]               dec_sel,
  input  logic                        clear,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid
);
  logic first, boundary, last;
  logic [KW-1:0] k_act, k_req;
  logic signed [ADC_WIDTH-1:0] avg;
  logic unused_bits;
  assign unused_bits = ^S_AXIS_tdata[AXIS_TDATA_WIDTH-1:ADC_WIDTH];
  assign k_req = dec_sel > KW'(LOG2_N_MAX) ? KW'(LOG2_N_MAX) : dec_sel;
  assign boundary = first || clear || last;
  boxcar_accumulator #(.ADC_WIDTH(ADC_WIDTH), .LOG2_N_MAX(LOG2_N_MAX)) u_acc (
    .clk(clk),
    .rst(rst),
    .valid(S_AXIS_tvalid),
    .clear(clear),
    .k(k_act),
    .sample(S_AXIS_tdata[ADC_WIDTH-1:0]),
    .last(last),
    .avg(avg)
  );
  // latch the window exponent at boundaries and register the packed output beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first <= 1'b1;
      k_act <= '0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tdata <= '0;
    end else begin
      first <= 1'b0;
      k_act <= boundary ? k_req : k_act;
      M_AXIS_tvalid <= last;
      if (last)
        M_AXIS_tdata <= {{(AXIS_TDATA_WIDTH-OUT_W){1'b0}}, {(OUT_W-ADC_WIDTH){avg[ADC_WIDTH-1]}}, avg};
    end
  end
endmodule
